// File: rtl/pwm_mon_pkg.sv
// pwm_mon_pkg: FSM states, lamp channel and fault-cause indices for the PWM lamp monitor
package pwm_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  localparam int NS_RED = 0, NS_YELLOW = 1, NS_GREEN = 2, EW_RED = 3, EW_YELLOW = 4, EW_GREEN = 5;
  localparam int F_CONFLICT = 0, F_MULTI = 1, F_DARK = 2, F_AMBIG = 3;
  function automatic logic many(logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/pwm_lamp_monitor_if.sv
// pwm_lamp_monitor_if: lamp drive lines under test, monitor control and decoded results
interface pwm_lamp_monitor_if;
  logic en, clear;
  logic NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green;
  logic [5:0] lamp_state;
  logic lamp_valid, fault;
  logic [3:0] fault_code;
  modport master (output en, clear, NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green,
                  input lamp_state, lamp_valid, fault, fault_code);
  modport slave (input en, clear, NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green,
                 output lamp_state, lamp_valid, fault, fault_code);
endinterface

// File: rtl/pwm_duty_counter.sv
// pwm_duty_counter: one lamp channel -- 2-flop synchronizer, per-window high count, threshold decode
module pwm_duty_counter #(
  parameter int WIN_BITS = 8,
  parameter int THRESH_LO = 16,
  parameter int THRESH_HI = 240
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic restart,
  input  logic win_end,
  output logic on,
  output logic amb
);
  localparam logic [WIN_BITS:0] LO = THRESH_LO[WIN_BITS:0];
  localparam logic [WIN_BITS:0] HI = THRESH_HI[WIN_BITS:0];
  logic [1:0] sync;
  logic [WIN_BITS:0] cnt, total;
  // total includes the current sample so the window-end cycle is counted
  assign total = cnt + (WIN_BITS+1)'(sync[1]);
  assign on = total >= HI;
  assign amb = !on && total > LO;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], din};
      cnt <= restart ? '0 : win_end ? (WIN_BITS+1)'(sync[1]) : total;
    end
endmodule

// File: rtl/pwm_lamp_monitor.sv
// pwm_lamp_monitor: decodes six PWM lamp drives per window and latches illegal-aspect faults
module pwm_lamp_monitor
  import pwm_mon_pkg::*;
#(
  parameter int WIN_BITS = 8,
  parameter int THRESH_LO = 16,
  parameter int THRESH_HI = 240
) (
  input  logic clk,
  input  logic rst,
  pwm_lamp_monitor_if.slave bus
);
  state_t st, st_nx;
  logic [WIN_BITS-1:0] wcnt;
  logic [5:0] din, on, amb, dec, lamp;
  logic [3:0] cause, code;
  logic active, win_end, restart, trip, valid;
  assign din = {bus.EW_Green, bus.EW_Yellow, bus.EW_Red, bus.NS_Green, bus.NS_Yellow, bus.NS_Red};
  assign active = st == FAULT || (st == RUN && bus.en);
  assign win_end = active && &wcnt;
  // a window end alongside clear is still reported; otherwise clear restarts the window
  assign restart = !active || (bus.clear && !win_end);
  for (genvar c = 0; c < 6; c++) begin : g_ch
    pwm_duty_counter #(.WIN_BITS(WIN_BITS), .THRESH_LO(THRESH_LO), .THRESH_HI(THRESH_HI)) u_ch (
      .clk(clk), .rst(rst), .din(din[c]), .restart(restart), .win_end(win_end),
      .on(on[c]), .amb(amb[c]));
  end
  assign dec = on | (amb & lamp);
  assign cause[F_CONFLICT] = (dec[NS_GREEN] | dec[NS_YELLOW]) & (dec[EW_GREEN] | dec[EW_YELLOW]);
  assign cause[F_MULTI] = many(dec[NS_GREEN:NS_RED]) | many(dec[EW_GREEN:EW_RED]);
  assign cause[F_DARK] = ~|dec[NS_GREEN:NS_RED] | ~|dec[EW_GREEN:EW_RED];
  assign cause[F_AMBIG] = |amb;
  assign trip = win_end && |cause;
  always_comb st_nx = trip ? FAULT : (st != FAULT || bus.clear) ? (bus.en ? RUN : IDLE) : st;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt <= '0;
      lamp <= '0;
      valid <= 1'b0;
      code <= '0;
    end else begin
      wcnt <= restart ? '0 : wcnt + WIN_BITS'(1);
      valid <= win_end;
      lamp <= win_end ? dec : lamp;
      code <= (bus.clear ? 4'b0 : code) | (win_end ? cause : 4'b0);
    end
  assign bus.lamp_state = lamp;
  assign bus.lamp_valid = valid;
  assign bus.fault_code = code;
  assign bus.fault = |code;
endmodule

// File: tb/tb_pwm_lamp_monitor.sv
// tb_pwm_lamp_monitor: scoreboard bench driving periodic PWM duties per lamp channel
module tb_pwm_lamp_monitor;
  import pwm_mon_pkg::*;
  localparam int WB = 4, TL = 3, TH = 12;
  typedef struct packed { logic [5:0] lamp; logic [3:0] fc; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int duty [6] = '{0, 0, 0, 0, 0, 0};
  int phase = 0, vec = 0, err = 0;
  logic [5:0] pat, m_lamp = '0;
  logic [3:0] m_fc = '0;
  exp_t sb [$];

  pwm_lamp_monitor_if bus();
  pwm_lamp_monitor #(.WIN_BITS(WB), .THRESH_LO(TL), .THRESH_HI(TH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // each channel is high for duty[i] of every 16 cycles, so any 16-cycle window counts exactly duty[i]
  initial begin
    {bus.EW_Green, bus.EW_Yellow, bus.EW_Red, bus.NS_Green, bus.NS_Yellow, bus.NS_Red} = '0;
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 16;
      for (int i = 0; i < 6; i++) pat[i] = phase < duty[i];
      {bus.EW_Green, bus.EW_Yellow, bus.EW_Red, bus.NS_Green, bus.NS_Yellow, bus.NS_Red} = pat;
    end
  end

  function automatic exp_t predict();
    exp_t e;
    logic a = 1'b0;
    e.lamp = m_lamp;
    for (int i = 0; i < 6; i++)
      if (duty[i] <= TL) e.lamp[i] = 1'b0;
      else if (duty[i] >= TH) e.lamp[i] = 1'b1;
      else a = 1'b1;
    e.fc = m_fc;
    e.fc[0] |= (e.lamp[1] | e.lamp[2]) & (e.lamp[4] | e.lamp[5]);
    e.fc[1] |= ($countones(e.lamp[2:0]) > 1) || ($countones(e.lamp[5:3]) > 1);
    e.fc[2] |= (e.lamp[2:0] == 3'b0) || (e.lamp[5:3] == 3'b0);
    e.fc[3] |= a;
    return e;
  endfunction

  task automatic push_exp();
    exp_t e = predict();
    m_lamp = e.lamp;
    m_fc = e.fc;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.lamp_valid && n < 60);
    if (!bus.lamp_valid) n = -1;
  endtask

  task automatic set_duty(input int a, b, c, d, e, f);
    duty = '{a, b, c, d, e, f};
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    bus.clear = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_lamp = '0;
    m_fc = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++;
    if (bus.lamp_state !== 6'b0 || bus.lamp_valid !== 1'b0 || bus.fault !== 1'b0 ||
        bus.fault_code !== 4'b0 || dut.st !== IDLE) begin
      err++;
      $display("FAIL reset: lamp=%b valid=%b fault=%b fc=%b st=%0d want all zero, IDLE",
               bus.lamp_state, bus.lamp_valid, bus.fault, bus.fault_code, dut.st);
    end
  endtask

  task automatic test_steady();
    exp_t e;
    int n;
    do_reset();
    set_duty(16, 0, 0, 0, 0, 16);
    repeat (3) push_exp();
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      e = sb.pop_front();
      vec++;
      if (n != (k == 0 ? 17 : 16) || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc || bus.fault !== |e.fc) begin
        err++;
        $display("FAIL steady[%0d]: gap=%0d lamp=%b fc=%b want gap=%0d lamp=%b fc=%b",
                 k, n, bus.lamp_state, bus.fault_code, k == 0 ? 17 : 16, e.lamp, e.fc);
      end
    end
    @(posedge clk);
    #1 vec++;
    if (bus.lamp_valid !== 1'b0) begin
      err++;
      $display("FAIL valid_pulse: valid=%b want 0 one cycle after pulse", bus.lamp_valid);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int n;
    bit seen = 0;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n < 0 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
      err++;
      $display("FAIL abort_pre: gap=%0d lamp=%b fc=%b want lamp=%b fc=%b", n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
    end
    repeat (9) @(posedge clk);
    #1 vec++;
    if (dut.wcnt !== 4'd9) begin
      err++;
      $display("FAIL abort_cycle: wcnt=%0d want 9", dut.wcnt);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1 if (bus.lamp_valid) seen = 1;
    end
    vec++;
    if (seen || bus.lamp_state !== m_lamp || dut.st !== IDLE || dut.wcnt !== 4'd0) begin
      err++;
      $display("FAIL abort_hold: valid_seen=%0d lamp=%b st=%0d wcnt=%0d want 0 %b IDLE 0",
               seen, bus.lamp_state, dut.st, dut.wcnt, m_lamp);
    end
    @(negedge clk);
    bus.en = 1'b1;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n != 17 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
      err++;
      $display("FAIL abort_restart: gap=%0d lamp=%b fc=%b want gap=17 lamp=%b fc=%b",
               n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    int n;
    do_reset();
    set_duty(0, 0, 16, 0, 0, 16);
    bus.en = 1'b1;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n != 17 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc || bus.fault !== 1'b1 || dut.st !== FAULT) begin
      err++;
      $display("FAIL conflict: gap=%0d lamp=%b fc=%b fault=%b st=%0d want gap=17 lamp=%b fc=%b fault=1 FAULT",
               n, bus.lamp_state, bus.fault_code, bus.fault, dut.st, e.lamp, e.fc);
    end
    @(negedge clk);
    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    vec++;
    if (dut.st !== FAULT || bus.fault !== 1'b1) begin
      err++;
      $display("FAIL fault_en_low: st=%0d fault=%b want FAULT 1", dut.st, bus.fault);
    end
    set_duty(16, 0, 0, 0, 0, 16);
    bus.clear = 1'b1;
    bus.en = 1'b1;
    m_fc = '0;
    @(posedge clk);
    #1 vec++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 4'b0 || dut.st !== RUN) begin
      err++;
      $display("FAIL clear: fault=%b fc=%b st=%0d want 0 0000 RUN", bus.fault, bus.fault_code, dut.st);
    end
    @(negedge clk);
    bus.clear = 1'b0;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n != 16 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc || bus.fault !== 1'b0) begin
      err++;
      $display("FAIL post_clear: gap=%0d lamp=%b fc=%b want gap=16 lamp=%b fc=%b", n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
    end
  endtask

  task automatic test_ambiguous();
    int tbl [4] = '{12, 8, 3, 11};
    exp_t e;
    int n;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.clear = 1'b1;
      m_fc = '0;
      @(negedge clk);
      bus.clear = 1'b0;
      set_duty(tbl[k], 0, 0, 0, 0, 16);
      bus.en = 1'b1;
      push_exp();
      wait_valid(n);
      e = sb.pop_front();
      vec++;
      if (n != 17 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
        err++;
        $display("FAIL ambiguous[duty=%0d]: gap=%0d lamp=%b fc=%b want gap=17 lamp=%b fc=%b",
                 tbl[k], n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    do_reset();
    set_duty(0, 0, 0, 0, 0, 0);
    bus.en = 1'b1;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n != 17 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
      err++;
      $display("FAIL dark: gap=%0d lamp=%b fc=%b want gap=17 lamp=%b fc=%b", n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
    end
    set_duty(16, 0, 16, 0, 0, 0);
    repeat (2) push_exp();
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      e = sb.pop_front();
      vec++;
      if (n < 0 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
        err++;
        $display("FAIL sticky[%0d]: gap=%0d lamp=%b fc=%b want lamp=%b fc=%b", k, n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
      end
    end
    set_duty(0, 0, 0, 0, 0, 0);
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n < 0 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
      err++;
      $display("FAIL sticky_dark: gap=%0d lamp=%b fc=%b want lamp=%b fc=%b", n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
    end
    repeat (15) @(posedge clk);
    #1 bus.clear = 1'b1;
    m_fc = '0;
    push_exp();
    @(posedge clk);
    #1 e = sb.pop_front();
    vec++;
    if (bus.lamp_valid !== 1'b1 || bus.fault_code !== e.fc || bus.lamp_state !== e.lamp || dut.st !== FAULT) begin
      err++;
      $display("FAIL clear_collide: valid=%b fc=%b lamp=%b st=%0d want 1 %b %b FAULT",
               bus.lamp_valid, bus.fault_code, bus.lamp_state, dut.st, e.fc, e.lamp);
    end
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n;
    do_reset();
    set_duty(0, 0, 16, 0, 0, 16);
    bus.en = 1'b1;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n != 17 || bus.fault_code !== e.fc || dut.st !== FAULT) begin
      err++;
      $display("FAIL pre_reset: gap=%0d fc=%b st=%0d want gap=17 fc=%b FAULT", n, bus.fault_code, dut.st, e.fc);
    end
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    bus.en = 1'b0;
    #1 vec++;
    if (bus.lamp_state !== 6'b0 || bus.lamp_valid !== 1'b0 || bus.fault !== 1'b0 ||
        bus.fault_code !== 4'b0 || dut.st !== IDLE || dut.wcnt !== 4'd0) begin
      err++;
      $display("FAIL async_reset: lamp=%b valid=%b fault=%b fc=%b st=%0d wcnt=%0d want zeros IDLE",
               bus.lamp_state, bus.lamp_valid, bus.fault, bus.fault_code, dut.st, dut.wcnt);
    end
    @(negedge clk);
    rst = 1'b0;
    m_lamp = '0;
    m_fc = '0;
    set_duty(16, 0, 0, 0, 0, 16);
    bus.en = 1'b1;
    push_exp();
    wait_valid(n);
    e = sb.pop_front();
    vec++;
    if (n != 17 || bus.lamp_state !== e.lamp || bus.fault_code !== e.fc) begin
      err++;
      $display("FAIL after_reset: gap=%0d lamp=%b fc=%b want gap=17 lamp=%b fc=%b", n, bus.lamp_state, bus.fault_code, e.lamp, e.fc);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_steady();
    test_abort();
    test_conflict();
    test_ambiguous();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
